// File: rtl/run_control_pkg.sv
// Shared definitions for the running-man controller and its datapath:
// sequencing states, motion phases, default geometry and colour codes.
package run_control_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLOORS,
        ST_WAIT,
        ST_ERASE,
        ST_UPDATE,
        ST_LOAD,
        ST_DRAW
    } state_t;

    typedef enum logic [1:0] {
        PH_GROUND,
        PH_RISE,
        PH_FALL
    } phase_t;

    // Default geometry and timing
    localparam int DEF_FRAME_CYCLES = 833333;
    localparam int DEF_X_POS        = 30;
    localparam int DEF_GROUND_Y     = 108;
    localparam int DEF_JUMP_HEIGHT  = 20;

    // Screen limits
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    // Colour codes shared with the pixel datapath
    localparam logic [2:0] COLOR_BG    = 3'b000;
    localparam logic [2:0] COLOR_FLOOR = 3'b010;
    localparam logic [2:0] COLOR_MAN   = 3'b111;

    // Counter width that stays legal for a 1-cycle frame
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/run_control_frame_timer.sv
// Free-running frame counter; frame_tick is high in the last cycle of
// every frame, i.e. in the cycle the counter wraps back to zero.
module run_control_frame_timer
    import run_control_pkg::*;
#(
    parameter int FRAME_CYCLES = DEF_FRAME_CYCLES
) (
    input  logic clk,
    input  logic reset,
    output logic frame_tick
);

    localparam int CNT_W = cnt_width(FRAME_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_CYCLES - 1);

    logic [CNT_W-1:0] count_reg;

    // Count 0..FRAME_CYCLES-1 and wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else if (count_reg == LAST) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign frame_tick = (count_reg == LAST);

endmodule

// File: rtl/run_control.sv
// Pass sequencer and per-frame motion controller for the running man.
// Orders floor / draw / erase passes, steps the jump arc once per frame
// and hands the new pose to the datapath between erase and draw.
module run_control
    import run_control_pkg::*;
#(
    parameter int FRAME_CYCLES = DEF_FRAME_CYCLES,
    parameter int X_POS        = DEF_X_POS,
    parameter int GROUND_Y     = DEF_GROUND_Y,
    parameter int JUMP_HEIGHT  = DEF_JUMP_HEIGHT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       jump_key,
    input  logic       crouch_key,
    input  logic       draw_floors_finish,
    input  logic       draw_man_finish,
    input  logic       erase_finish,
    output logic       drawing_floors,
    output logic       draw_man,
    output logic       erase,
    output logic       plot,
    output logic       ld_x,
    output logic       ld_y,
    output logic       ld_man_style,
    output logic [7:0] x_in,
    output logic [6:0] y_in,
    output logic       man_style
);

    localparam logic [6:0] GROUND_ROW = 7'(GROUND_Y);
    localparam logic [4:0] LAST_RISE  = 5'(JUMP_HEIGHT - 1);
    localparam logic [7:0] COLUMN     = 8'(X_POS);

    state_t     state_reg, state_next;
    phase_t     phase_reg, phase_next;
    logic [6:0] pos_y_reg, pos_y_next;
    logic [4:0] jump_cnt_reg, jump_cnt_next;
    logic       style_reg, style_next;
    logic       frame_pending_reg;
    logic       frame_tick;
    logic       pending_clear;
    logic       floors_reg, draw_reg, erase_reg, ld_reg;

    run_control_frame_timer #(
        .FRAME_CYCLES(FRAME_CYCLES)
    ) u_frame_timer (
        .clk       (clk),
        .reset     (reset),
        .frame_tick(frame_tick)
    );

    // A tick always wins over the clear so a frame is never lost
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_pending_reg <= 1'b0;
        end else if (frame_tick) begin
            frame_pending_reg <= 1'b1;
        end else if (pending_clear) begin
            frame_pending_reg <= 1'b0;
        end
    end

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; only the finish flag of the current pass matters
    always_comb begin
        state_next    = state_reg;
        pending_clear = 1'b0;
        case (state_reg)
            ST_IDLE:   state_next = ST_FLOORS;
            ST_FLOORS: if (draw_floors_finish) state_next = ST_LOAD;
            ST_LOAD:   state_next = ST_DRAW;
            ST_DRAW:   if (draw_man_finish) state_next = ST_WAIT;
            ST_WAIT: begin
                if (frame_pending_reg) begin
                    state_next    = ST_ERASE;
                    pending_clear = 1'b1;
                end
            end
            ST_ERASE:  if (erase_finish) state_next = ST_UPDATE;
            ST_UPDATE: state_next = ST_LOAD;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Registered Moore requests and load strobe, aligned with the state register
    always_ff @(posedge clk) begin
        if (reset) begin
            floors_reg <= 1'b0;
            draw_reg   <= 1'b0;
            erase_reg  <= 1'b0;
            ld_reg     <= 1'b0;
        end else begin
            floors_reg <= (state_next == ST_FLOORS);
            draw_reg   <= (state_next == ST_DRAW);
            erase_reg  <= (state_next == ST_ERASE);
            ld_reg     <= (state_next == ST_LOAD);
        end
    end

    // One motion step: jump arc and crouch pose from the sampled keys
    always_comb begin
        phase_next    = phase_reg;
        pos_y_next    = pos_y_reg;
        jump_cnt_next = jump_cnt_reg;
        style_next    = 1'b1;
        case (phase_reg)
            PH_GROUND: begin
                if (jump_key) begin
                    pos_y_next    = pos_y_reg - 7'd1;
                    jump_cnt_next = 5'd0;
                    // a one-row jump peaks immediately
                    phase_next    = (LAST_RISE == 5'd0) ? PH_FALL : PH_RISE;
                end else if (crouch_key) begin
                    style_next = 1'b0;
                end
            end
            PH_RISE: begin
                pos_y_next    = pos_y_reg - 7'd1;
                jump_cnt_next = jump_cnt_reg + 5'd1;
                if (jump_cnt_reg + 5'd1 >= LAST_RISE) begin
                    phase_next = PH_FALL;
                end
            end
            PH_FALL: begin
                if (pos_y_reg + 7'd1 >= GROUND_ROW) begin
                    pos_y_next = GROUND_ROW;
                    phase_next = PH_GROUND;
                end else begin
                    pos_y_next = pos_y_reg + 7'd1;
                end
            end
            default: begin
                phase_next = PH_GROUND;
                pos_y_next = GROUND_ROW;
            end
        endcase
    end

    // Motion registers advance only in UPDATE and hold through LOAD/DRAW/ERASE
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_reg    <= PH_GROUND;
            pos_y_reg    <= GROUND_ROW;
            jump_cnt_reg <= 5'd0;
            style_reg    <= 1'b1;
        end else if (state_reg == ST_UPDATE) begin
            phase_reg    <= phase_next;
            pos_y_reg    <= pos_y_next;
            jump_cnt_reg <= jump_cnt_next;
            style_reg    <= style_next;
        end
    end

    assign drawing_floors = floors_reg;
    assign draw_man       = draw_reg;
    assign erase          = erase_reg;
    assign plot           = floors_reg | draw_reg | erase_reg;
    assign ld_x           = ld_reg;
    assign ld_y           = ld_reg;
    assign ld_man_style   = ld_reg;
    assign x_in           = COLUMN;
    assign y_in           = pos_y_reg;
    assign man_style      = style_reg;

endmodule

// File: tb/tb_run_control.sv
// Scoreboarded bench for run_control: a datapath emulator answers the
// pass requests, a frame-level jump model predicts every loaded pose, and
// a monitor checks loads, request gaps, plot and frame alignment.
module tb_run_control;

    localparam int FC = 50;
    localparam int XP = 30;
    localparam int GY = 108;
    localparam int JH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       jump_key = 1'b0;
    logic       crouch_key = 1'b0;
    logic       draw_floors_finish = 1'b0;
    logic       draw_man_finish = 1'b0;
    logic       erase_finish = 1'b0;
    logic       drawing_floors, draw_man, erase, plot;
    logic       ld_x, ld_y, ld_man_style;
    logic [7:0] x_in;
    logic [6:0] y_in;
    logic       man_style;

    run_control #(
        .FRAME_CYCLES(FC),
        .X_POS       (XP),
        .GROUND_Y    (GY),
        .JUMP_HEIGHT (JH)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .jump_key          (jump_key),
        .crouch_key        (crouch_key),
        .draw_floors_finish(draw_floors_finish),
        .draw_man_finish   (draw_man_finish),
        .erase_finish      (erase_finish),
        .drawing_floors    (drawing_floors),
        .draw_man          (draw_man),
        .erase             (erase),
        .plot              (plot),
        .ld_x              (ld_x),
        .ld_y              (ld_y),
        .ld_man_style      (ld_man_style),
        .x_in              (x_in),
        .y_in              (y_in),
        .man_style         (man_style)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int s;
    } pose_t;

    pose_t exp_q[$];
    int    total = 0;
    int    bad = 0;
    int    air_t = 0;      // frames into the current jump, 0 = on the ground
    int    cyc = 0;
    int    grid_skip = 0;
    int    load_no = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Frame-level jump model: the arc is a triangle of height JH over 2*JH frames
    task automatic model_step(input bit j, input bit c, output pose_t p);
        int h;
        p.s = 1;
        if (air_t == 0) begin
            if (j) air_t = 1;
            else if (c) p.s = 0;
        end else begin
            air_t++;
            if (air_t == 2 * JH) air_t = 0;
        end
        h = (air_t <= JH) ? air_t : 2 * JH - air_t;
        p.x = XP;
        p.y = GY - h;
    endtask

    function automatic bit req_sel(input int w);
        case (w)
            0:       return drawing_floors;
            1:       return draw_man;
            default: return erase;
        endcase
    endfunction

    task automatic wait_for(input int which, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (req_sel(which)) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL wait_request%0d actual=absent required=present", which);
        end
    endtask

    // Monitor: pops expected poses on every load and checks pass framing
    bit prev_ld = 1'b0, prev_draw = 1'b0, prev_erase = 1'b0, after_erase = 1'b0;
    int gap = 0;
    int grid_ref = 0;
    bit ref_valid = 1'b0;

    always @(negedge clk) begin
        pose_t e;
        if (reset) begin
            ref_valid   = 1'b0;
            after_erase = 1'b0;
            prev_ld     = 1'b0;
            prev_draw   = 1'b0;
            prev_erase  = 1'b0;
        end else begin
            check("plot_or", int'(plot), int'(drawing_floors | draw_man | erase));
            if (ld_x || ld_y || ld_man_style) begin
                check("ld_strobes_equal", int'({ld_x, ld_man_style}), int'({ld_y, ld_y}));
            end
            if (ld_y) begin
                check("ld_single_cycle", int'(prev_ld), 0);
                if (exp_q.size() == 0) begin
                    check("load_expected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    load_no++;
                    $display("load %0d: x=%0d y=%0d style=%0d (want %0d %0d %0d)",
                             load_no, x_in, y_in, man_style, e.x, e.y, e.s);
                    check("load_x", int'(x_in), e.x);
                    check("load_y", int'(y_in), e.y);
                    check("load_style", int'(man_style), e.s);
                end
            end
            if (erase) begin
                after_erase = 1'b1;
                gap = 0;
            end else if (draw_man && !prev_draw && after_erase) begin
                check("erase_draw_gap", gap, 2);
                after_erase = 1'b0;
            end else if (!plot && after_erase) begin
                gap++;
            end
            if (erase && !prev_erase) begin
                if (!ref_valid) begin
                    ref_valid = 1'b1;
                    grid_ref  = cyc;
                end else if (grid_skip > 0) begin
                    grid_skip--;
                end else begin
                    check("frame_alignment", (cyc - grid_ref) % FC, 0);
                end
            end
            prev_ld    = ld_y;
            prev_draw  = draw_man;
            prev_erase = erase;
        end
    end

    // Floor pass: 20 cycles of request, then the initial pose load
    task automatic do_floors();
        bit ok;
        int cnt;
        pose_t p;
        wait_for(0, 20, ok);
        cnt = 1;
        repeat (19) begin
            @(negedge clk);
            if (drawing_floors) cnt++;
        end
        check("floors_len", cnt, 20);
        air_t = 0;
        p.x = XP;
        p.y = GY;
        p.s = 1;
        exp_q.push_back(p);
        draw_floors_finish = 1'b1;
        @(negedge clk);
        check("floors_end", int'(drawing_floors), 0);
        wait_for(1, 5, ok);
        draw_floors_finish = 1'b0;
    endtask

    // One frame starting in DRAW: finish draw, erase with given keys, back to DRAW
    task automatic run_frame(input bit j, input bit c, input int edly, input int ddly);
        bit ok;
        pose_t p;
        repeat (ddly) @(negedge clk);
        draw_man_finish = 1'b1;
        wait_for(2, 400, ok);
        draw_man_finish = 1'b0;
        jump_key   = j;
        crouch_key = c;
        model_step(j, c, p);
        exp_q.push_back(p);
        repeat (edly - 1) @(negedge clk);
        if (edly > FC) grid_skip = 3;
        erase_finish = 1'b1;
        wait_for(1, 10, ok);
        erase_finish = 1'b0;
    endtask

    bit [1:0] script [22] = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00,
                              2'b00, 2'b00, 2'b01, 2'b01, 2'b11, 2'b01, 2'b01, 2'b01,
                              2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};

    initial begin
        bit ok;
        repeat (3) @(negedge clk);
        check("rst_floors", int'(drawing_floors), 0);
        check("rst_draw", int'(draw_man), 0);
        check("rst_erase", int'(erase), 0);
        check("rst_plot", int'(plot), 0);
        check("rst_ld", int'(ld_y), 0);
        check("rst_x", int'(x_in), XP);
        check("rst_y", int'(y_in), GY);
        check("rst_style", int'(man_style), 1);
        reset = 1'b0;

        do_floors();
        for (int f = 0; f < 22; f++) begin
            run_frame(script[f][1], script[f][0], $urandom_range(1, 8), $urandom_range(1, 8));
        end
        // Late erase spanning three frame ticks
        run_frame(1'b0, 1'b0, 170, 3);
        for (int f = 0; f < 50; f++) begin
            run_frame($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                      ($urandom_range(0, 11) == 0) ? 160 : $urandom_range(1, 8),
                      $urandom_range(1, 8));
        end
        // Get airborne, then reset in the middle of the next erase
        run_frame(1'b1, 1'b0, 2, 2);
        check("queue_empty_before_reset", exp_q.size(), 0);
        draw_man_finish = 1'b1;
        wait_for(2, 400, ok);
        draw_man_finish = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("midrst_erase", int'(erase), 0);
        check("midrst_plot", int'(plot), 0);
        check("midrst_ld", int'(ld_y), 0);
        check("midrst_y", int'(y_in), GY);
        check("midrst_style", int'(man_style), 1);
        @(negedge clk);
        reset = 1'b0;
        jump_key   = 1'b0;
        crouch_key = 1'b0;
        do_floors();
        for (int f = 0; f < 6; f++) begin
            run_frame($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                      $urandom_range(1, 8), $urandom_range(1, 8));
        end
        check("queue_empty_at_end", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
